// File: rtl/conv_seq_ctrl_if.sv
// Job/strobe bundle between the layer controller (master) and the
// convolve sequencer (slave). The sequencer's strobes feed memory and MAC.
interface conv_seq_ctrl_if #(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 10
);
   logic              start;
   logic              abort;
   logic [CNT_W-1:0]  n_taps;
   logic [CNT_W-1:0]  n_outputs;
   logic [ADDR_W-1:0] sig_base;
   logic [ADDR_W-1:0] sig_step;
   logic [ADDR_W-1:0] wgt_base;
   logic              busy;
   logic              done;
   logic              rd_en;
   logic [ADDR_W-1:0] sig_addr;
   logic [ADDR_W-1:0] wgt_addr;
   logic              clken;
   logic              s_convout;
   logic              en_mult_r;
   logic              en_sat;
   logic              out_valid;
   logic [CNT_W-1:0]  out_index;

   modport master (
      output start, abort, n_taps, n_outputs, sig_base, sig_step, wgt_base,
      input  busy, done, rd_en, sig_addr, wgt_addr, clken, s_convout,
             en_mult_r, en_sat, out_valid, out_index
   );

   modport slave (
      input  start, abort, n_taps, n_outputs, sig_base, sig_step, wgt_base,
      output busy, done, rd_en, sig_addr, wgt_addr, clken, s_convout,
             en_mult_r, en_sat, out_valid, out_index
   );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Tap/output sequencer for the convolve MAC: issues reads, aligns MAC
// strobes with returning data, then saturates and flags each dot product.
module conv_seq_ctrl #(
   parameter int ADDR_W      = 10,
   parameter int CNT_W       = 10,
   parameter int MEM_LATENCY = 1,
   parameter int MAC_LATENCY = 1
) (
   input logic           clk,
   input logic           reset,
   conv_seq_ctrl_if.slave bus
);
   localparam int DRAIN_N = MEM_LATENCY + MAC_LATENCY;
   localparam int DW      = $clog2(DRAIN_N + 1);

   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, SAT, OUT, FIN} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  taps_q, outs_q, tap, row;
   logic [ADDR_W-1:0] step_q, wbase_q, row_addr;
   logic [DW-1:0]     drain_cnt;
   logic [MEM_LATENCY-1:0] vld_pipe, first_pipe;

   logic accept, zero_job, kill, issue, last_tap, last_out, drain_done;

   assign accept     = (state == IDLE) && bus.start && !bus.abort;
   assign zero_job   = (bus.n_taps == '0) || (bus.n_outputs == '0);
   assign kill       = bus.abort && (state != IDLE);
   assign issue      = (state == ISSUE);
   assign last_tap   = (tap == taps_q - CNT_W'(1));
   assign last_out   = (row == outs_q - CNT_W'(1));
   assign drain_done = (drain_cnt == DW'(DRAIN_N - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.busy      = (state != IDLE);
      bus.done      = (state == FIN);
      bus.rd_en     = issue;
      bus.sig_addr  = '0;
      bus.wgt_addr  = '0;
      bus.en_mult_r = (state == ISSUE) || (state == DRAIN) ||
                      (state == SAT)   || (state == OUT);
      bus.en_sat    = (state == SAT) || (state == OUT);
      bus.out_valid = (state == OUT);
      bus.out_index = '0;
      bus.clken     = vld_pipe[MEM_LATENCY-1];
      bus.s_convout = vld_pipe[MEM_LATENCY-1] & first_pipe[MEM_LATENCY-1];
      if (issue) begin
         bus.sig_addr = row_addr + ADDR_W'(tap);
         bus.wgt_addr = wbase_q + ADDR_W'(tap);
      end
      if (state == OUT) bus.out_index = row;

      if (kill) state_nxt = IDLE;
      else begin
         case (state)
            IDLE:  if (accept) state_nxt = zero_job ? FIN : ISSUE;
            ISSUE: if (last_tap) state_nxt = DRAIN;
            DRAIN: if (drain_done) state_nxt = SAT;
            SAT:   state_nxt = OUT;
            OUT:   state_nxt = last_out ? FIN : ISSUE;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // row_addr tracks sig_base + j*sig_step incrementally, avoiding a multiplier
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         taps_q    <= '0;
         outs_q    <= '0;
         step_q    <= '0;
         wbase_q   <= '0;
         row_addr  <= '0;
         tap       <= '0;
         row       <= '0;
         drain_cnt <= '0;
      end else if (kill) begin
         tap       <= '0;
         row       <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               taps_q   <= bus.n_taps;
               outs_q   <= bus.n_outputs;
               step_q   <= bus.sig_step;
               wbase_q  <= bus.wgt_base;
               row_addr <= bus.sig_base;
               tap      <= '0;
               row      <= '0;
            end
            ISSUE: begin
               tap       <= last_tap ? '0 : tap + CNT_W'(1);
               drain_cnt <= '0;
            end
            DRAIN: drain_cnt <= drain_cnt + DW'(1);
            OUT: if (!last_out) begin
               row      <= row + CNT_W'(1);
               row_addr <= row_addr + step_q;
            end
            default: ;
         endcase
      end
   end

   // Tap flags ride alongside the memory access so clken meets the data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_pipe   <= '0;
         first_pipe <= '0;
      end else if (kill) begin
         vld_pipe   <= '0;
         first_pipe <= '0;
      end else begin
         vld_pipe[0]   <= issue;
         first_pipe[0] <= issue && (tap == '0);
         for (int i = 1; i < MEM_LATENCY; i++) begin
            vld_pipe[i]   <= vld_pipe[i-1];
            first_pipe[i] <= first_pipe[i-1];
         end
      end
   end
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: two instances (latencies 1/1 and 2/3) share the
// job inputs; traces are compared cycle by cycle with a per-job timing model.
module tb_conv_seq_ctrl;
   localparam int AW = 10;
   localparam int CW = 10;
   typedef logic [37:0] vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   conv_seq_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) bus1 ();
   conv_seq_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) bus2 ();

   conv_seq_ctrl #(.ADDR_W(AW), .CNT_W(CW), .MEM_LATENCY(1), .MAC_LATENCY(1))
      u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
   conv_seq_ctrl #(.ADDR_W(AW), .CNT_W(CW), .MEM_LATENCY(2), .MAC_LATENCY(3))
      u_dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

   assign bus2.start     = bus1.start;
   assign bus2.abort     = bus1.abort;
   assign bus2.n_taps    = bus1.n_taps;
   assign bus2.n_outputs = bus1.n_outputs;
   assign bus2.sig_base  = bus1.sig_base;
   assign bus2.sig_step  = bus1.sig_step;
   assign bus2.wgt_base  = bus1.wgt_base;

   vec_t obs1, obs2;
   assign obs1 = {bus1.busy, bus1.done, bus1.rd_en, bus1.sig_addr, bus1.wgt_addr,
                  bus1.clken, bus1.s_convout, bus1.en_mult_r, bus1.en_sat,
                  bus1.out_valid, bus1.out_index};
   assign obs2 = {bus2.busy, bus2.done, bus2.rd_en, bus2.sig_addr, bus2.wgt_addr,
                  bus2.clken, bus2.s_convout, bus2.en_mult_r, bus2.en_sat,
                  bus2.out_valid, bus2.out_index};

   // Stand-in memories and MAC for the 1/1 instance
   logic signed [7:0] sig_mem [1024];
   logic signed [7:0] wgt_mem [1024];
   logic signed [7:0] sd, wd;
   int acc = 0;
   always @(posedge clk) begin
      if (bus1.rd_en) begin
         sd <= sig_mem[bus1.sig_addr];
         wd <= wgt_mem[bus1.wgt_addr];
      end
      if (bus1.clken) acc <= (bus1.s_convout ? 0 : acc) + int'(sd) * int'(wd);
   end

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   task automatic check(input string tag, input vec_t got, input vec_t exp);
      checks++;
      assert (got === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int sat8(input int x);
      if (x > 127) return 127;
      if (x < -128) return -128;
      return x;
   endfunction

   function automatic int dot(input int nt, input int sb, input int ss, input int wb, input int j);
      int s = 0;
      for (int t = 0; t < nt; t++)
         s += int'(sig_mem[(sb + j*ss + t) & 1023]) * int'(wgt_mem[(wb + t) & 1023]);
      return s;
   endfunction

   // Expected strobes in cycle c after the start edge (abort raised in cycle ab)
   function automatic vec_t model(input int c, input int ml, input int mc, input int nt,
                                  input int no, input int sb, input int ss, input int wb,
                                  input int ab);
      logic b, d, rd, ck, sc, em, es, ov;
      logic [9:0] sa, wa, oi;
      int p, tot, j, k;
      b = 0; d = 0; rd = 0; ck = 0; sc = 0; em = 0; es = 0; ov = 0;
      sa = '0; wa = '0; oi = '0;
      if (ab > 0 && c > ab) return '0;
      if (nt == 0 || no == 0) begin
         b = (c == 1);
         d = (c == 1);
      end else begin
         p   = nt + ml + mc + 2;
         tot = no * p;
         if (c <= tot) begin
            j  = (c - 1) / p;
            k  = (c - 1) % p;
            b  = 1;
            em = 1;
            rd = (k < nt);
            if (rd) begin
               sa = 10'((sb + j*ss + k) & 1023);
               wa = 10'((wb + k) & 1023);
            end
            ck = (k >= ml) && (k < ml + nt);
            sc = (k == ml);
            es = (k >= p - 2);
            ov = (k == p - 1);
            if (ov) oi = 10'(j);
         end else if (c == tot + 1) begin
            b = 1;
            d = 1;
         end
      end
      return {b, d, rd, sa, wa, ck, sc, em, es, ov, oi};
   endfunction

   task automatic run_job(input int nt, input int no, input int sb, input int ss,
                          input int wb, input int ab, input int bs, output int last_acc);
      vec_t e1, e2;
      int total;
      total    = (nt == 0 || no == 0) ? 3 : no * (nt + 7) + 3;
      last_acc = 0;
      @(negedge clk);
      bus1.start     = 1'b1;
      bus1.n_taps    = CW'(nt);
      bus1.n_outputs = CW'(no);
      bus1.sig_base  = AW'(sb);
      bus1.sig_step  = AW'(ss);
      bus1.wgt_base  = AW'(wb);
      for (int c = 1; c <= total; c++) begin
         @(negedge clk);
         e1 = model(c, 1, 1, nt, no, sb, ss, wb, ab);
         e2 = model(c, 2, 3, nt, no, sb, ss, wb, ab);
         check($sformatf("d1 nt%0d no%0d c%0d", nt, no, c), obs1, e1);
         check($sformatf("d2 nt%0d no%0d c%0d", nt, no, c), obs2, e2);
         if (e1[10]) begin
            check_int($sformatf("acc j%0d c%0d", e1[9:0], c), acc, dot(nt, sb, ss, wb, int'(e1[9:0])));
            last_acc = acc;
         end
         bus1.start = (c == bs);
         bus1.abort = (c == ab);
         if (c == 1 || c == bs) begin
            bus1.n_taps    = CW'($urandom_range(1, 9));
            bus1.n_outputs = CW'($urandom_range(1, 9));
            bus1.sig_base  = AW'($urandom);
            bus1.sig_step  = AW'($urandom);
            bus1.wgt_base  = AW'($urandom);
         end
      end
      bus1.start = 1'b0;
      bus1.abort = 1'b0;
   endtask

   task automatic fill(input int mode);
      for (int i = 0; i < 1024; i++) begin
         sig_mem[i] = (mode == 0) ? 8'($urandom) : 8'(mode);
         wgt_mem[i] = (mode == 0) ? 8'($urandom) : 8'(mode);
      end
   endtask

   initial begin
      int la, nt, no, ab, bs;
      bus1.start = 0; bus1.abort = 0; bus1.n_taps = '0; bus1.n_outputs = '0;
      bus1.sig_base = '0; bus1.sig_step = '0; bus1.wgt_base = '0;
      fill(0);
      #12;
      check("reset d1", obs1, '0);
      check("reset d2", obs2, '0);
      @(negedge clk);
      reset = 1'b1;

      // Base job: all-64 data gives 12288 >> 9 = 24
      fill(64);
      run_job(3, 2, 16, 2, 0, 0, 0, la);
      check_int("conv 64x64", sat8(la >>> 9), 24);

      // Long kernel of 127s saturates
      fill(127);
      run_job(64, 1, 0, 1, 0, 0, 0, la);
      check_int("conv sat", sat8(la >>> 9), 127);

      fill(0);
      run_job(0, 2, 5, 1, 0, 0, 0, la);
      run_job(4, 0, 5, 1, 0, 0, 0, la);
      run_job(1, 2, 1020, 3, 1022, 0, 0, la);

      // Start while busy (cycle 2) then abort in cycle 4
      run_job(3, 2, 16, 2, 0, 4, 2, la);
      run_job(2, 1, 40, 1, 9, 0, 0, la);

      for (int r = 0; r < 14; r++) begin
         nt = $urandom_range(0, 6);
         no = $urandom_range(0, 3);
         bs = (nt != 0 && no != 0) ? 2 : 0;
         ab = ($urandom_range(0, 2) == 0) ? $urandom_range(3, 25) : 0;
         run_job(nt, no, $urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(0, 1023), ab, bs, la);
      end

      // Asynchronous reset in the middle of ISSUE
      @(negedge clk);
      bus1.start = 1'b1; bus1.n_taps = 10'd5; bus1.n_outputs = 10'd2;
      bus1.sig_base = 10'd3; bus1.sig_step = 10'd4; bus1.wgt_base = 10'd1;
      @(negedge clk);
      bus1.start = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("async rst d1", obs1, '0);
      check("async rst d2", obs2, '0);
      @(negedge clk);
      check("held rst d1", obs1, '0);
      @(negedge clk);
      reset = 1'b1;
      run_job(2, 2, 100, 7, 3, 0, 0, la);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
